// File: rtl/dp_ram_bus_pkg.sv
// Shared types and limits for the dual-port RAM with bus-style handshake.
package dp_ram_bus_pkg;

  localparam int unsigned MAX_RD_LATENCY = 4;
  localparam int unsigned MAX_STALL      = 15;
  localparam int unsigned STALL_CNT_W    = $clog2(MAX_STALL + 1);

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } gnt_state_e;

endpackage

// File: rtl/dp_ram_bus_port.sv
// Per-port grant FSM with programmable stall and fixed-latency response pipeline.
module dp_ram_bus_port
  import dp_ram_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned STALL_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_lat
    $error("dp_ram_bus_port: RD_LATENCY out of range");
  end
  if (STALL_CYCLES > MAX_STALL) begin : g_bad_stall
    $error("dp_ram_bus_port: STALL_CYCLES out of range");
  end

  localparam logic [STALL_CNT_W-1:0] StallCnt = STALL_CNT_W'(STALL_CYCLES);

  gnt_state_e             state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    if (STALL_CYCLES == 0) begin
      gnt = req_i;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_i) begin
            state_d = StWait;
            cnt_d   = STALL_CNT_W'(1);
          end
        end
        StWait: begin
          if (!req_i) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == StallCnt) begin
            gnt     = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign gnt_o = gnt & rst_n;

  // Each stage's data only moves with its valid bit, so the last stage holds between responses.
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] dat_d [RD_LATENCY];

  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = gnt_o;
    dat_d[0] = gnt_o ? (we_i ? '0 : rdata_i) : dat_q[0];
    for (int unsigned k = 1; k < RD_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      vld_q   <= '0;
      for (int unsigned k = 0; k < RD_LATENCY; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  assign rvalid_o = vld_q[RD_LATENCY-1];
  assign rdata_o  = dat_q[RD_LATENCY-1];

endmodule

// File: rtl/dp_ram_bus.sv
// Dual-port byte-writable RAM; read-first on R/W collisions, port B wins W/W byte collisions.
module dp_ram_bus
  import dp_ram_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned STALL_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_a_i,
  output logic                    gnt_a_o,
  input  logic [ADDR_WIDTH-1:0]   addr_a_i,
  input  logic                    we_a_i,
  input  logic [DATA_WIDTH/8-1:0] be_a_i,
  input  logic [DATA_WIDTH-1:0]   wdata_a_i,
  output logic                    rvalid_a_o,
  output logic [DATA_WIDTH-1:0]   rdata_a_o,
  input  logic                    req_b_i,
  output logic                    gnt_b_o,
  input  logic [ADDR_WIDTH-1:0]   addr_b_i,
  input  logic                    we_b_i,
  input  logic [DATA_WIDTH/8-1:0] be_b_i,
  input  logic [DATA_WIDTH-1:0]   wdata_b_i,
  output logic                    rvalid_b_o,
  output logic [DATA_WIDTH-1:0]   rdata_b_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = ADDR_WIDTH - OffW;
  localparam int unsigned NumWords = 2 ** IdxW;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
    $error("dp_ram_bus: DATA_WIDTH must be 32 or 64");
  end
  if (ADDR_WIDTH <= OffW) begin : g_bad_aw
    $error("dp_ram_bus: ADDR_WIDTH too small for DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [NumWords];
  logic [IdxW-1:0]       idx_a, idx_b;
  logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;
  logic                  unused_addr;

  assign idx_a       = addr_a_i[ADDR_WIDTH-1:OffW];
  assign idx_b       = addr_b_i[ADDR_WIDTH-1:OffW];
  assign unused_addr = ^{addr_a_i[OffW-1:0], addr_b_i[OffW-1:0]};

  // Combinational read sampled by the port pipeline at the grant edge gives read-first.
  assign rd_word_a = mem_q[idx_a];
  assign rd_word_b = mem_q[idx_b];

  // Port B is written last so it overrides A on bytes both enable.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (gnt_a_o && we_a_i && be_a_i[i]) mem_q[idx_a][8*i +: 8] <= wdata_a_i[8*i +: 8];
      if (gnt_b_o && we_b_i && be_b_i[i]) mem_q[idx_b][8*i +: 8] <= wdata_b_i[8*i +: 8];
    end
  end

  function automatic logic [7:0] readByte(input logic [ADDR_WIDTH-1:0] byte_addr);
    return mem_q[byte_addr[ADDR_WIDTH-1:OffW]][{byte_addr[OffW-1:0], 3'b000} +: 8];
  endfunction

  task automatic writeByte(input logic [ADDR_WIDTH-1:0] byte_addr, input logic [7:0] val);
    mem_q[byte_addr[ADDR_WIDTH-1:OffW]][{byte_addr[OffW-1:0], 3'b000} +: 8] <= val;
  endtask

  dp_ram_bus_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RD_LATENCY  (RD_LATENCY),
    .STALL_CYCLES(STALL_CYCLES)
  ) u_port_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req_a_i),
    .we_i    (we_a_i),
    .rdata_i (rd_word_a),
    .gnt_o   (gnt_a_o),
    .rvalid_o(rvalid_a_o),
    .rdata_o (rdata_a_o)
  );

  dp_ram_bus_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RD_LATENCY  (RD_LATENCY),
    .STALL_CYCLES(STALL_CYCLES)
  ) u_port_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req_b_i),
    .we_i    (we_b_i),
    .rdata_i (rd_word_b),
    .gnt_o   (gnt_b_o),
    .rvalid_o(rvalid_b_o),
    .rdata_o (rdata_b_o)
  );

endmodule

// File: tb/tb_dp_ram_bus.sv
// Directed bench for dp_ram_bus: scoreboarded responses plus reset and stall scenarios.
module tb_dp_ram_bus;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Main instance: latency 2, no stall.
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [15:0] addr_a = '0, addr_b = '0;
  logic [3:0]  be_a = '0, be_b = '0;
  logic [31:0] wdata_a = '0, wdata_b = '0;
  logic        gnt_a_o, gnt_b_o, rvalid_a_o, rvalid_b_o;
  logic [31:0] rdata_a_o, rdata_b_o;

  dp_ram_bus #(
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (32),
    .RD_LATENCY  (2),
    .STALL_CYCLES(0)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a_i   (req_a),
    .gnt_a_o   (gnt_a_o),
    .addr_a_i  (addr_a),
    .we_a_i    (we_a),
    .be_a_i    (be_a),
    .wdata_a_i (wdata_a),
    .rvalid_a_o(rvalid_a_o),
    .rdata_a_o (rdata_a_o),
    .req_b_i   (req_b),
    .gnt_b_o   (gnt_b_o),
    .addr_b_i  (addr_b),
    .we_b_i    (we_b),
    .be_b_i    (be_b),
    .wdata_b_i (wdata_b),
    .rvalid_b_o(rvalid_b_o),
    .rdata_b_o (rdata_b_o)
  );

  // Stall instance: 3 stall cycles, latency 1; port B idle.
  logic        rst_s = 1'b0, req_s = 1'b0, idle_s = 1'b0;
  logic [7:0]  addr_s = '0;
  logic [3:0]  be_s = '0;
  logic [31:0] wdata_s = '0;
  logic        gnt_s, rvalid_s, gnt_sb, rvalid_sb;
  logic [31:0] rdata_s, rdata_sb;

  dp_ram_bus #(
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (32),
    .RD_LATENCY  (1),
    .STALL_CYCLES(3)
  ) u_stall (
    .clk       (clk),
    .rst_n     (rst_s),
    .req_a_i   (req_s),
    .gnt_a_o   (gnt_s),
    .addr_a_i  (addr_s),
    .we_a_i    (idle_s),
    .be_a_i    (be_s),
    .wdata_a_i (wdata_s),
    .rvalid_a_o(rvalid_s),
    .rdata_a_o (rdata_s),
    .req_b_i   (idle_s),
    .gnt_b_o   (gnt_sb),
    .addr_b_i  (addr_s),
    .we_b_i    (idle_s),
    .be_b_i    (be_s),
    .wdata_b_i (wdata_s),
    .rvalid_b_o(rvalid_sb),
    .rdata_b_o (rdata_sb)
  );

  typedef struct packed {
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } op_t;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  localparam op_t Nop = '0;

  function automatic op_t rd(input logic [15:0] addr, input logic [31:0] exp);
    return '{req: 1'b1, we: 1'b0, addr: addr, be: 4'h0, wd: 32'h0, exp: exp};
  endfunction

  function automatic op_t wr(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] wd);
    return '{req: 1'b1, we: 1'b1, addr: addr, be: be, wd: wd, exp: 32'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on both ports; responses are expected RD_LATENCY=2 cycles after grant.
  task automatic issue(input op_t a, input op_t b);
    req_a = a.req; we_a = a.we; addr_a = a.addr; be_a = a.be; wdata_a = a.wd;
    req_b = b.req; we_b = b.we; addr_b = b.addr; be_b = b.be; wdata_b = b.wd;
    #1;
    chk("gnt_a", 32'(gnt_a_o), 32'(a.req));
    chk("gnt_b", 32'(gnt_b_o), 32'(b.req));
    if (a.req) q_a.push_back('{due: cyc + 2, data: a.exp});
    if (b.req) q_b.push_back('{due: cyc + 2, data: b.exp});
    @(posedge clk); #1;
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rvalid_a_o) begin
        n_tests++;
        assert (q_a.size() > 0)
        else begin
          n_fail++;
          $error("FAIL sb_a_extra: observed rvalid=1 expected rvalid=0");
        end
        if (q_a.size() > 0) begin
          chk("sb_a_cycle", cyc, q_a[0].due);
          chk("sb_a_data", rdata_a_o, q_a[0].data);
          void'(q_a.pop_front());
        end
      end else if (q_a.size() > 0 && q_a[0].due <= cyc) begin
        chk("sb_a_missing", 32'(rvalid_a_o), 32'd1);
        void'(q_a.pop_front());
      end
      if (rvalid_b_o) begin
        n_tests++;
        assert (q_b.size() > 0)
        else begin
          n_fail++;
          $error("FAIL sb_b_extra: observed rvalid=1 expected rvalid=0");
        end
        if (q_b.size() > 0) begin
          chk("sb_b_cycle", cyc, q_b[0].due);
          chk("sb_b_data", rdata_b_o, q_b[0].data);
          void'(q_b.pop_front());
        end
      end else if (q_b.size() > 0 && q_b[0].due <= cyc) begin
        chk("sb_b_missing", 32'(rvalid_b_o), 32'd1);
        void'(q_b.pop_front());
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 6; i++) @(posedge clk);
    #1;
    chk("q_a_empty", q_a.size(), 32'd0);
    chk("q_b_empty", q_b.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a pending request on A.
    req_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_gnt_a", 32'(gnt_a_o), 32'd0);
      chk("rst_rvalid_a", 32'(rvalid_a_o), 32'd0);
      chk("rst_rdata_a", rdata_a_o, 32'd0);
    end
    req_a = 1'b0;
    rst_n = 1'b1;

    issue(wr(16'h10, 4'hF, 32'hDEADBEEF), Nop);
    issue(Nop, rd(16'h13, 32'hDEADBEEF));
    issue(wr(16'h10, 4'h5, 32'h11223344), Nop);
    issue(rd(16'h10, 32'hDE22BE44), rd(16'h12, 32'hDE22BE44));
    issue(wr(16'h20, 4'h3, 32'hAAAAAAAA), wr(16'h20, 4'hE, 32'h55555555));
    issue(rd(16'h20, 32'h555555AA), Nop);
    issue(wr(16'h30, 4'hF, 32'h0), Nop);
    issue(wr(16'h30, 4'hF, 32'h12345678), rd(16'h30, 32'h0));
    issue(Nop, rd(16'h30, 32'h12345678));
    issue(wr(16'h10, 4'h0, 32'hFFFFFFFF), Nop);
    issue(rd(16'h10, 32'hDE22BE44), Nop);
    u_dut.writeByte(16'h31, 8'hEE);
    issue(Nop, rd(16'h33, 32'h1234EE78));
    drain();

    chk("bd_rd_20", 32'(u_dut.readByte(16'h20)), 32'hAA);
    chk("bd_rd_23", 32'(u_dut.readByte(16'h23)), 32'h55);
    chk("hold_rvalid_b", 32'(rvalid_b_o), 32'd0);
    chk("hold_rdata_b", rdata_b_o, 32'h1234EE78);
    chk("hold_rdata_a", rdata_a_o, 32'hDE22BE44);

    // Granted read then reset: the response must be dropped.
    req_a = 1'b1; we_a = 1'b0; addr_a = 16'h10;
    #1;
    chk("drop_gnt_a", 32'(gnt_a_o), 32'd1);
    @(posedge clk); #1;
    req_a = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drop_rvalid_a", 32'(rvalid_a_o), 32'd0);
      @(posedge clk); #1;
    end
    chk("drop_rdata_a", rdata_a_o, 32'd0);
    rst_n = 1'b1;
    drain();

    // Stall: request at cycle 0 is granted at cycle 3.
    rst_s = 1'b1;
    req_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_gnt", 32'(gnt_s), (i == 3) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    req_s = 1'b0;
    chk("stall_rvalid", 32'(rvalid_s), 32'd1);
    #1;
    chk("stall_gnt_after", 32'(gnt_s), 32'd0);
    @(posedge clk); #1;
    chk("stall_rvalid_once", 32'(rvalid_s), 32'd0);

    // Same request, reset asserted at cycle 1.
    req_s = 1'b1;
    #1;
    chk("stall_rst_gnt0", 32'(gnt_s), 32'd0);
    @(posedge clk); #1;
    rst_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_rst_gnt", 32'(gnt_s), 32'd0);
      chk("stall_rst_rvalid", 32'(rvalid_s), 32'd0);
      @(posedge clk); #1;
    end
    req_s = 1'b0;
    rst_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("stall_post_gnt", 32'(gnt_s), 32'd0);
      chk("stall_post_rvalid", 32'(rvalid_s), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dp_ram_bus.md
DP_RAM_BUS -- requirements
Module: dp_ram_bus

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, byte-address width per port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, word width; legal values are 32 or 64.
REQ-003 The block SHALL have parameter RD_LATENCY, default 1, cycles from grant to rvalid; legal range 1..4.
REQ-004 The block SHALL have parameter STALL_CYCLES, default 0, cycles from request to grant; legal range 0..15.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising edge) and rst_n input 1 (synchronous, active-low).
REQ-006 The block SHALL have req_a_i / req_b_i, input, 1 bit, request.
REQ-007 The block SHALL have gnt_a_o / gnt_b_o, output, 1 bit, request accepted this cycle.
REQ-008 The block SHALL have addr_a_i / addr_b_i, input, ADDR_WIDTH bits, byte address.
REQ-009 The block SHALL have we_a_i / we_b_i, input, 1 bit, 1 = write, 0 = read.
REQ-010 The block SHALL have be_a_i / be_b_i, input, DATA_WIDTH/8 bits, byte enables; these apply to writes only.
REQ-011 The block SHALL have wdata_a_i / wdata_b_i, input, DATA_WIDTH bits, write data.
REQ-012 The block SHALL have rvalid_a_o / rvalid_b_o, output, 1 bit, response valid.
REQ-013 The block SHALL have rdata_a_o / rdata_b_o, output, DATA_WIDTH bits, read data.

Function
REQ-014 Memory SHALL hold 2**(ADDR_WIDTH - log2(DATA_WIDTH/8)) words; word index = addr >> log2(DATA_WIDTH/8); low address bits ignored (0x13 accesses word 4 when DATA_WIDTH = 32).
REQ-015 Each port SHALL run an independent grant FSM: IDLE -> WAIT on req with STALL_CYCLES > 0; WAIT counts STALL_CYCLES cycles, then grants and returns to IDLE.
REQ-016 With STALL_CYCLES = 0, gnt SHALL equal req combinationally, allowing back-to-back grants every cycle.
REQ-017 If req drops while in WAIT, the FSM SHALL return to IDLE with no grant and no response.
REQ-018 A transaction SHALL take effect only in its gnt cycle; the write updates enabled bytes at that clock edge, and the read samples the word at that same edge.
REQ-019 Every granted transaction (read or write) SHALL produce exactly one rvalid pulse exactly RD_LATENCY cycles after the gnt cycle; responses stay in order, and rvalid has no backpressure.
REQ-020 rdata SHALL carry the read word during a read response, SHALL be 0 during a write response, and SHALL hold its last value when rvalid = 0.
REQ-021 On a read/write collision (one port reads the word the other port writes in the same cycle), the read SHALL return the old data (read-first).
REQ-022 On a write/write collision to the same word in the same cycle, port B SHALL win on bytes enabled by both ports; bytes enabled by only one port SHALL take that port's data.
REQ-023 A write with be = 0 SHALL leave memory unchanged but still be granted and still produce a response.
REQ-024 The block SHALL provide simulation-public backdoor readByte(byte_addr) and writeByte(byte_addr, val) routines that bypass the ports and have zero latency.

Reset
REQ-025 While rst_n = 0 at a clock edge, the following SHALL hold: gnt = 0, rvalid = 0, rdata = 0, FSM = IDLE, stall counter = 0, and the response pipeline is cleared.
REQ-026 Transactions in flight when reset is asserted SHALL be dropped with no rvalid, and grants SHALL be suppressed while reset is asserted.
REQ-027 Memory contents SHALL NOT be reset.

Structure
REQ-028 The shared package dp_ram_bus_pkg SHALL hold the grant-FSM state enum, MAX_RD_LATENCY = 4, and MAX_STALL = 15.
REQ-029 The per-port grant FSM and response pipeline SHALL live in sub-module dp_ram_bus_port, instantiated twice; the memory array and collision logic SHALL stay in the top level.
REQ-030 Illegal parameter values SHALL cause an elaboration-time error.

Verification
REQ-031 Reset scenario: rst_n = 0 for 2 cycles with req_a_i = 1 -> gnt_a_o = 0, rvalid_a_o = 0, rdata_a_o = 0 throughout.
REQ-032 Latency scenario (RD_LATENCY = 2): port A writes 0xDEADBEEF to 0x10 with be = 1111, then port B reads 0x13 -> rvalid_b_o is asserted 2 cycles after the grant and rdata_b_o = 0xDEADBEEF.
REQ-033 Byte-enable scenario: write 0x11223344 with be = 0101 over 0xDEADBEEF, then read -> 0xDE22BE44.
REQ-034 Write/write collision scenario: A writes 0xAAAAAAAA with be = 0011 and B writes 0x55555555 with be = 1110, same cycle, same address 0x20 -> a subsequent read returns 0x5555550xAA... specifically bytes 3..1 = 0x55 and byte 0 = 0xAA, giving 0x555555AA.
REQ-035 Read-first scenario: word 0x30 holds 0; in the same cycle A writes 0x12345678 to 0x30 and B reads 0x30 -> B returns 0x00000000, and a following read returns 0x12345678.
REQ-036 Stall scenario (STALL_CYCLES = 3): req asserted at cycle 0 -> gnt at cycle 3; repeating the request with reset asserted at cycle 1 -> no gnt and no rvalid.
